paddle_move_ctrl: RTL and testbench

//  Turns the debounced up/down pushbutton levels of one player into paddle motion.

---
 rtl/pong_pkg.sv | 31 +++
 rtl/paddle_move_ctrl_hold_repeat_fsm.sv | 103 ++++++++++
 rtl/paddle_move_ctrl.sv | 93 +++++++++
 tb/tb_paddle_move_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: paddle FSM states, button direction codes,
// default play-field limits and the button-to-direction decoder.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_DELAY,
        ST_REPEAT
    } fsm_state_e;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DN
    } dir_e;

    localparam int unsigned DEF_POS_MIN  = 0;
    localparam int unsigned DEF_POS_MAX  = 400;
    localparam int unsigned DEF_POS_INIT = 200;

    // Buttons are active-low; both or neither pressed means no direction.
    function automatic dir_e decode_dir(input logic up_n, input logic dn_n);
        case ({up_n, dn_n})
            2'b01:   return DIR_UP;
            2'b10:   return DIR_DN;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/paddle_move_ctrl_hold_repeat_fsm.sv
// Press/hold/auto-repeat sequencer: turns a held direction into step pulses
// (one immediate step, a first repeat after REPEAT_DELAY, then every REPEAT_PERIOD).
module hold_repeat_fsm
    import pong_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 20_000_000,
    parameter int unsigned REPEAT_PERIOD = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  dir_e dir,
    output logic step,
    output dir_e step_dir
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    // DELAY exits one count early so the STEP state lands exactly
    // REPEAT_DELAY clocks after the first move.
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 2);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    fsm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_e             act_dir_q, act_dir_d;
    logic             rep_q, rep_d;
    logic             dir_changed;

    assign dir_changed = (dir != act_dir_q);
    assign step_dir    = act_dir_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        act_dir_d = act_dir_q;
        rep_d     = rep_q;
        step      = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dir != DIR_NONE) begin
                        state_d   = ST_STEP;
                        act_dir_d = dir;
                        rep_d     = 1'b0;
                        cnt_d     = '0;
                    end
                end
                ST_STEP: begin
                    step  = 1'b1;
                    cnt_d = '0;
                    if (dir_changed) state_d = ST_IDLE;
                    else             state_d = rep_q ? ST_REPEAT : ST_DELAY;
                end
                ST_DELAY: begin
                    if (dir_changed) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DELAY_LAST) begin
                        state_d = ST_STEP;
                        rep_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (dir_changed) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == PERIOD_LAST) begin
                        step  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            act_dir_q <= DIR_NONE;
            rep_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            act_dir_q <= act_dir_d;
            rep_q     <= rep_d;
        end
    end

endmodule

// File: rtl/paddle_move_ctrl.sv
// One player's paddle: registers the debounced buttons, sequences steps via
// hold_repeat_fsm and owns the clamped paddle position register.
module paddle_move_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 20_000_000,
    parameter int unsigned REPEAT_PERIOD = 2_500_000,
    parameter int unsigned POS_W         = 10,
    parameter int unsigned POS_MIN       = DEF_POS_MIN,
    parameter int unsigned POS_MAX       = DEF_POS_MAX,
    parameter int unsigned POS_INIT      = DEF_POS_INIT,
    parameter int unsigned STEP          = 4
) (
    input  logic             in_clk,
    input  logic             rst_n,
    input  logic             up_pb,
    input  logic             dn_pb,
    input  logic             enable,
    input  logic             recenter,
    output logic [POS_W-1:0] pos,
    output logic             move_pulse,
    output logic             at_limit
);

    localparam logic [POS_W-1:0] MIN_V  = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] MAX_V  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] INIT_V = POS_W'(POS_INIT);
    localparam logic [POS_W-1:0] STEP_V = POS_W'(STEP);
    localparam logic [POS_W-1:0] LO_THR = POS_W'(POS_MIN + STEP);
    localparam logic [POS_W-1:0] HI_THR = POS_W'(POS_MAX - STEP);
    localparam logic INIT_AT_LIMIT = (POS_INIT == POS_MIN) || (POS_INIT == POS_MAX);

    dir_e             dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d, next_pos;
    logic             move_pulse_q, move_pulse_d;
    logic             at_limit_q, at_limit_d;
    logic             fsm_clear, fsm_step;
    dir_e             fsm_dir;

    assign fsm_clear = recenter | ~enable;

    hold_repeat_fsm #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_fsm (
        .clk     (in_clk),
        .rst_n   (rst_n),
        .clear   (fsm_clear),
        .dir     (dir_q),
        .step    (fsm_step),
        .step_dir(fsm_dir)
    );

    always_comb begin
        dir_d    = decode_dir(up_pb, dn_pb);
        next_pos = pos_q;
        // Thresholds are compared before subtracting/adding so pos never wraps.
        case (fsm_dir)
            DIR_UP:  next_pos = (pos_q < LO_THR) ? MIN_V : pos_q - STEP_V;
            DIR_DN:  next_pos = (pos_q > HI_THR) ? MAX_V : pos_q + STEP_V;
            default: next_pos = pos_q;
        endcase

        pos_d        = pos_q;
        move_pulse_d = 1'b0;
        if (recenter) begin
            pos_d = INIT_V;
        end else if (enable && fsm_step) begin
            pos_d        = next_pos;
            move_pulse_d = (next_pos != pos_q);
        end
        at_limit_d = (pos_d == MIN_V) || (pos_d == MAX_V);
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q        <= DIR_NONE;
            pos_q        <= INIT_V;
            move_pulse_q <= 1'b0;
            at_limit_q   <= INIT_AT_LIMIT;
        end else begin
            dir_q        <= dir_d;
            pos_q        <= pos_d;
            move_pulse_q <= move_pulse_d;
            at_limit_q   <= at_limit_d;
        end
    end

    assign pos        = pos_q;
    assign move_pulse = move_pulse_q;
    assign at_limit   = at_limit_q;

endmodule

// File: tb/tb_paddle_move_ctrl.sv
// Scoreboard bench for paddle_move_ctrl: stimulus queues expected moves
// (position, limit flag, cycle); a monitor pops one per move_pulse.
module tb_paddle_move_ctrl;

    localparam int unsigned POS_W = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             up_pb;
    logic             dn_pb;
    logic             enable;
    logic             recenter;
    logic [POS_W-1:0] pos;
    logic             move_pulse;
    logic             at_limit;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_on   = 1'b0;

    typedef struct {
        int pos;
        int al;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    paddle_move_ctrl #(
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(3),
        .POS_W        (POS_W),
        .POS_MIN      (0),
        .POS_MAX      (20),
        .POS_INIT     (8),
        .STEP         (4)
    ) dut (
        .in_clk    (clk),
        .rst_n     (rst_n),
        .up_pb     (up_pb),
        .dn_pb     (dn_pb),
        .enable    (enable),
        .recenter  (recenter),
        .pos       (pos),
        .move_pulse(move_pulse),
        .at_limit  (at_limit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void expect_move(input int p, input int al, input int at_cyc);
        exp_t e;
        e.pos = p;
        e.al  = al;
        e.cyc = at_cyc;
        exp_q.push_back(e);
    endfunction

    // Monitor: every move_pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on && move_pulse) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_move actual pos=%0d at_limit=%0d cyc=%0d required=no move",
                             pos, at_limit, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(pos) != e.pos || int'(at_limit) != e.al || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL move actual pos=%0d at_limit=%0d cyc=%0d required pos=%0d at_limit=%0d cyc=%0d",
                                 pos, at_limit, cyc, e.pos, e.al, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int e;
        int r;
        rst_n    = 1'b1;
        up_pb    = 1'b1;
        dn_pb    = 1'b1;
        enable   = 1'b1;
        recenter = 1'b0;

        // 1. asynchronous reset mid-cycle, then idle buttons
        #23 rst_n = 1'b0;
        #1;
        chk("reset_pos", int'(pos), 8);
        chk("reset_move_pulse", int'(move_pulse), 0);
        chk("reset_at_limit", int'(at_limit), 0);
        tick(2);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        tick(50);
        chk("idle_pos", int'(pos), 8);

        // 2. short up press: exactly one step, two edges after sampling
        c = cyc;
        up_pb = 1'b0;
        expect_move(4, 0, c + 3);
        tick(2);
        up_pb = 1'b1;
        tick(20);
        chk("single_press_pos", int'(pos), 4);

        // 3. hold down: step, repeat after 8, then every 3, clamp at 20
        recenter = 1'b1;
        tick(1);
        recenter = 1'b0;
        chk("recenter_pos", int'(pos), 8);
        chk("recenter_no_pulse", int'(move_pulse), 0);
        c = cyc;
        dn_pb = 1'b0;
        expect_move(12, 0, c + 3);
        expect_move(16, 0, c + 11);
        expect_move(20, 1, c + 14);
        tick(40);
        dn_pb = 1'b1;
        tick(10);
        chk("hold_dn_pos", int'(pos), 20);
        chk("hold_dn_at_limit", int'(at_limit), 1);

        // 4. both pressed: no motion; releasing up gives a fresh DN sequence
        recenter = 1'b1;
        tick(1);
        recenter = 1'b0;
        up_pb = 1'b0;
        dn_pb = 1'b0;
        tick(20);
        chk("both_pressed_pos", int'(pos), 8);
        c = cyc;
        up_pb = 1'b1;
        expect_move(12, 0, c + 3);
        expect_move(16, 0, c + 11);
        tick(12);
        dn_pb = 1'b1;
        tick(10);
        chk("release_up_pos", int'(pos), 16);

        // 5. enable freeze, step on enable rise, recenter during repeat
        recenter = 1'b1;
        tick(1);
        recenter = 1'b0;
        c = cyc;
        up_pb = 1'b0;
        expect_move(4, 0, c + 3);
        tick(5);
        enable = 1'b0;
        tick(20);
        chk("disabled_pos", int'(pos), 4);
        e = cyc;
        enable = 1'b1;
        expect_move(0, 1, e + 2);
        tick(20);
        chk("enable_step_pos", int'(pos), 0);
        r = cyc;
        recenter = 1'b1;
        expect_move(4, 0, r + 3);
        tick(1);
        recenter = 1'b0;
        chk("recenter_repeat_pos", int'(pos), 8);
        chk("recenter_repeat_pulse", int'(move_pulse), 0);
        chk("recenter_repeat_at_limit", int'(at_limit), 0);
        tick(3);
        up_pb = 1'b1;
        tick(10);
        chk("after_recenter_pos", int'(pos), 4);

        // 6. from 4 holding up: reach 0, clamp, never wrap
        c = cyc;
        up_pb = 1'b0;
        expect_move(0, 1, c + 3);
        tick(30);
        chk("clamp_min_pos", int'(pos), 0);
        chk("clamp_min_at_limit", int'(at_limit), 1);
        up_pb = 1'b1;
        tick(5);

        chk("pending_expectations", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
